// File: rtl/aes192_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the iterative AES-192 decryptor.
package aes192_pkg;

    typedef enum logic [2:0] {IDLE, KEYEXP, READY, ROUND, DONE} state_t;

    localparam int unsigned NR     = 12;
    localparam int unsigned NK     = 6;
    localparam int unsigned NWORDS = 54;

    localparam logic [7:0] RCON [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                        8'h10, 8'h20, 8'h40, 8'h80};

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254: six square-and-multiply steps reach a^127, one more square.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int unsigned i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
        return gmul(r, r);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes192_inv_round.sv
// One shared inverse AES round; InvMixColumns is bypassed on the final round.
module aes192_inv_round (
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last_round,
    output logic [127:0] next_state
);
    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ark;
    logic [127:0] mc;

    inv_shift_rows  u_isr (.din(state), .dout(sr));
    inv_subByte     u_isb (.din(sr), .dout(sb));
    add_round_key   u_ark (.din(sb), .rk(rk), .dout(ark));
    inv_mix_columns u_imc (.din(ark), .dout(mc));

    assign next_state = last_round ? ark : mc;
endmodule

module inv_shift_rows (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    // Byte r+4c sits at bits [127-8(r+4c) -: 8]; row r rotates right by r columns.
    always_comb begin
        dout = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+4-r)%4)) -: 8];
    end
endmodule

module inv_subByte
    import aes192_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < 16; i++)
            dout[8*i+7 -: 8] = inv_sbox(din[8*i+7 -: 8]);
    end
endmodule

module add_round_key (
    input  logic [127:0] din,
    input  logic [127:0] rk,
    output logic [127:0] dout
);
    assign dout = din ^ rk;
endmodule

module inv_mix_columns
    import aes192_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    always_comb begin
        dout = '0;
        for (int unsigned c = 0; c < 4; c++)
            dout[127-32*c -: 32] = mix_col(din[127-32*c -: 32]);
    end
endmodule

// File: rtl/aes192_dec_iter_ctrl.sv
// Iterative AES-192 decryptor: 8-cycle key schedule into a word store, then one inverse round per clock.
module aes192_dec_iter_ctrl
    import aes192_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [191:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         key_loaded,
    output logic         busy
);
    state_t       state;
    logic [2:0]   step;
    logic [3:0]   rnd;
    logic [127:0] state_reg;
    logic [31:0]  w [NWORDS];

    logic [5:0]   kbase;
    logic [5:0]   rbase;
    logic [3:0]   rk_idx;
    logic [191:0] kexp_in;
    logic [191:0] kexp_out;
    logic [127:0] rk;
    logic [127:0] round_out;
    logic         key_hs;
    logic         blk_hs;

    assign key_ready = (state == IDLE) || (state == READY);
    assign in_ready  = (state == READY) && !key_valid;
    assign key_hs    = key_valid && key_ready;
    assign blk_hs    = in_valid && in_ready;
    assign busy      = (state == KEYEXP) || (state == ROUND) || (state == DONE);
    assign data_out  = state_reg;

    // Outside ROUND the round-key mux points at rk12 for the initial whitening XOR.
    assign rk_idx = (state == ROUND) ? rnd : 4'(NR);
    assign rbase  = 6'(rk_idx) * 6'd4;
    assign kbase  = 6'(step) * 6'd6;

    always_comb begin
        kexp_in = '0;
        rk      = '0;
        for (int unsigned i = 0; i < NK; i++)
            kexp_in[191-32*i -: 32] = w[kbase + 6'(i)];
        for (int unsigned i = 0; i < 4; i++)
            rk[127-32*i -: 32] = w[rbase + 6'(i)];
    end

    key_expansion_192 u_kexp (
        .key_in  (kexp_in),
        .rcon    ({RCON[step], 24'h0}),
        .key_out (kexp_out)
    );

    aes192_inv_round u_round (
        .state      (state_reg),
        .rk         (rk),
        .last_round (rnd == 4'd0),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (key_hs) begin
            for (int unsigned i = 0; i < NK; i++)
                w[6'(i)] <= key_in[191-32*i -: 32];
        end else if (state == KEYEXP) begin
            for (int unsigned i = 0; i < NK; i++)
                w[kbase + 6'd6 + 6'(i)] <= kexp_out[191-32*i -: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            rnd        <= '0;
            state_reg  <= '0;
            out_valid  <= 1'b0;
            key_loaded <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_hs) begin
                        step       <= '0;
                        key_loaded <= 1'b0;
                        state      <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    step <= step + 3'd1;
                    if (step == 3'd7) begin
                        key_loaded <= 1'b1;
                        state      <= READY;
                    end
                end
                READY: begin
                    if (key_hs) begin
                        step       <= '0;
                        key_loaded <= 1'b0;
                        state      <= KEYEXP;
                    end else if (blk_hs) begin
                        state_reg <= data_in ^ rk;
                        rnd       <= 4'(NR - 1);
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    if (rnd == 4'd0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module key_expansion_192
    import aes192_pkg::*;
(
    input  logic [191:0] key_in,
    input  logic [31:0]  rcon,
    output logic [191:0] key_out
);
    logic [31:0] w0, w1, w2, w3, w4, w5;
    logic [31:0] rot;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3, n4, n5;

    assign {w0, w1, w2, w3, w4, w5} = key_in;
    assign rot = {w5[23:0], w5[31:24]};
    assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ rcon;
    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign n4  = w4 ^ n3;
    assign n5  = w5 ^ n4;
    assign key_out = {n0, n1, n2, n3, n4, n5};
endmodule

// File: tb/tb_aes192_dec_iter_ctrl.sv
// Directed bench for the iterative AES-192 decryptor using FIPS-197 and SP800-38A known answers.
module tb_aes192_dec_iter_ctrl;

    localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] PT_C2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] KEY_SP = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] CT_SP1 = 128'hbd334f1d6e45f25ff712a214571fa5cc;
    localparam logic [127:0] PT_SP1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_SP2 = 128'h974104846d0ad3ad7734ecb3ecee4eef;
    localparam logic [127:0] PT_SP2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    typedef struct {
        logic [191:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [191:0] key_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] data_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] data_out;
    logic         key_loaded;
    logic         busy;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    aes192_dec_iter_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .key_loaded (key_loaded),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key_ready"},  192'(key_ready),  192'd1);
        chk({tag, "_in_ready"},   192'(in_ready),   192'd0);
        chk({tag, "_out_valid"},  192'(out_valid),  192'd0);
        chk({tag, "_data_out"},   192'(data_out),   192'd0);
        chk({tag, "_key_loaded"}, 192'(key_loaded), 192'd0);
        chk({tag, "_busy"},       192'(busy),       192'd0);
    endtask

    task automatic wait_in_ready();
        int unsigned n = 0;
        #1;
        while (!in_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("in_ready_timeout", 192'(in_ready), 192'd1);
    endtask

    task automatic wait_out_valid(output logic [127:0] pt, output int unsigned lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        chk("out_valid_timeout", 192'(out_valid), 192'd1);
        pt = data_out;
    endtask

    task automatic load_key(input logic [191:0] k, output int unsigned lat);
        int unsigned n = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_in = k;
        #1;
        while (!key_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("key_ready_timeout", 192'(key_ready), 192'd1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!key_loaded && lat < 40);
    endtask

    task automatic decrypt(input logic [127:0] ct, output logic [127:0] pt, output int unsigned lat);
        @(negedge clk);
        in_valid = 1'b1;
        data_in = ct;
        wait_in_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out_valid(pt, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        logic [127:0] pt;
        logic [127:0] p1;
        int unsigned lat;
        int unsigned t1;
        int unsigned t2;
        int unsigned n;
        logic seen;
        logic stable;

        vecs[0] = '{key: KEY_C2, ct: CT_C2,  pt: PT_C2};
        vecs[1] = '{key: KEY_SP, ct: CT_SP1, pt: PT_SP1};
        vecs[2] = '{key: KEY_SP, ct: CT_SP2, pt: PT_SP2};

        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // A block offered with no key loaded must never be taken.
        in_valid = 1'b1;
        data_in = CT_C2;
        seen = 1'b0;
        repeat (10) begin
            #1;
            if (in_ready || out_valid || busy) seen = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("idle_no_accept", 192'(seen), 192'd0);

        for (int i = 0; i < 3; i++) begin
            load_key(vecs[i].key, lat);
            chk($sformatf("vec%0d_key_latency", i), 192'(lat), 192'd9);
            decrypt(vecs[i].ct, pt, lat);
            chk($sformatf("vec%0d_latency", i), 192'(lat), 192'd13);
            chk($sformatf("vec%0d_plaintext", i), 192'(pt), 192'(vecs[i].pt));
        end

        // Back-to-back blocks with in_valid held and out_ready high.
        @(negedge clk);
        in_valid = 1'b1;
        data_in = CT_SP1;
        wait_in_ready();
        t1 = cyc;
        @(posedge clk); #1;
        data_in = CT_SP2;
        p1 = '0;
        n = 0;
        do begin
            @(negedge clk); #1;
            if (out_valid) p1 = data_out;
            n++;
        end while (!in_ready && n < 40);
        t2 = cyc;
        chk("b2b_gap", 192'(t2 - t1), 192'd14);
        chk("b2b_first_pt", 192'(p1), 192'(PT_SP1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out_valid(pt, lat);
        chk("b2b_second_pt", 192'(pt), 192'(PT_SP2));

        // Back-pressure: result held while out_ready is low, other inputs probed.
        @(negedge clk);
        out_ready = 1'b0;
        decrypt(CT_SP1, pt, lat);
        chk("bp_pt", 192'(pt), 192'(PT_SP1));
        key_valid = 1'b1;
        key_in = KEY_C2;
        in_valid = 1'b1;
        data_in = CT_SP2;
        stable = 1'b1;
        repeat (20) begin
            #1;
            if (!out_valid || data_out !== PT_SP1 || in_ready || key_ready || !busy) stable = 1'b0;
            @(negedge clk);
        end
        chk("bp_stable", 192'(stable), 192'd1);
        key_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_release_out_valid", 192'(out_valid), 192'd0);
        chk("bp_release_key_ready", 192'(key_ready), 192'd1);

        // Key and block offered together: the key wins, the block waits for the new schedule.
        @(negedge clk);
        key_valid = 1'b1;
        key_in = KEY_C2;
        in_valid = 1'b1;
        data_in = CT_C2;
        #1;
        chk("kb_in_ready", 192'(in_ready), 192'd0);
        chk("kb_key_ready", 192'(key_ready), 192'd1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!in_ready && n < 40);
        chk("kb_keyexp_cycles", 192'(n), 192'd9);
        chk("kb_key_loaded", 192'(key_loaded), 192'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out_valid(pt, lat);
        chk("kb_latency", 192'(lat), 192'd13);
        chk("kb_pt", 192'(pt), 192'(PT_C2));

        // Asynchronous reset in the middle of ROUND, then reload and decrypt again.
        @(negedge clk);
        in_valid = 1'b1;
        data_in = CT_C2;
        wait_in_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("mid_round_busy", 192'(busy), 192'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_key_loaded", 192'(key_loaded), 192'd0);
        load_key(KEY_C2, lat);
        chk("reload_key_latency", 192'(lat), 192'd9);
        decrypt(CT_C2, pt, lat);
        chk("reload_pt", 192'(pt), 192'(PT_C2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes192_dec_iter_ctrl.md
# aes192_dec_iter_ctrl

Iterative AES-192 decryption engine controller. It accepts a 192-bit key, expands and stores all 13 round keys over 8 cycles, then decrypts 128-bit blocks one inverse round per clock through a single shared round datapath. It is the area-reduced sequential counterpart of the fully unrolled 12-round decryptor and reuses the existing key_expansion_192, add_round_key, inv_shift_rows, inv_subByte and inv_mix_columns leaf modules. It sits between a valid/ready ciphertext source and a valid/ready plaintext sink.

## Interface
- No parameters. Constants are fixed by AES-192: Nr = 12, Nk = 6, 54 key words stored.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_valid  in  1  key_in is presented
- key_ready  out  1  key accepted when key_valid && key_ready
- key_in  in  192  cipher key; bits [191:160] = w0
- in_valid  in  1  ciphertext presented
- in_ready  out  1  block accepted when in_valid && in_ready
- data_in  in  128  ciphertext; bits [127:120] = state byte 0 (FIPS-197 column-major)
- out_valid  out  1  plaintext valid
- out_ready  in  1  sink accepts plaintext
- data_out  out  128  plaintext, same byte order as data_in
- key_loaded  out  1  round-key store holds a complete schedule
- busy  out  1  high in KEYEXP, ROUND, DONE

## Operation
- Key store: 54 × 32-bit words w[0..53]. Round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[52..53] unused.
- FSM states: IDLE, KEYEXP, READY, ROUND, DONE.
- IDLE: key_ready=1, in_ready=0. Key handshake → w[0..5]=key_in, step=0, key_loaded=0, go KEYEXP.
- KEYEXP: each cycle, w[6(step+1) .. 6(step+1)+5] = key_expansion_192(w[6step..6step+5], rcon[step]) with rcon = {8'h01<<step, 24'h0}. After step 7 is written, key_loaded=1, go READY. key_ready=0, in_ready=0.
- READY: key_ready=1; in_ready = !key_valid (a key load has priority over a block in the same cycle). Key handshake → KEYEXP as from IDLE. Block handshake → state_reg = data_in ^ rk12, rnd = 11, go ROUND.
- ROUND: each cycle, for rnd 11..1: state_reg = InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_rnd); for rnd 0: state_reg = InvSubBytes(InvShiftRows(state_reg)) ^ rk0, then go DONE. rnd decrements by 1 per cycle; no wrap.
- DONE: out_valid=1, data_out = state_reg, held stable until out_ready. Handshake → READY. key_ready=0, in_ready=0.
- Only one block in flight; no new key while a block is in ROUND or DONE.
- Input-side key_valid/in_valid ignored outside their ready windows; the source must hold them until accepted.

## Timing
- Reset (async, rst_n low): state=IDLE, key_ready=1, in_ready=0, out_valid=0, data_out=0, key_loaded=0, busy=0, rnd=0, step=0. Key store contents are don't-care but key_loaded=0 blocks use.
- Key load: handshake at cycle K; KEYEXP during K+1..K+8; in_ready may be high from K+9.
- Decrypt latency: block handshake at cycle T; out_valid high from cycle T+13, i.e. 12 round cycles after the load edge. Throughput with out_ready=1: one block per 14 cycles (handshake, 12 rounds, DONE).
- Back-pressure: out_ready low in DONE holds out_valid and data_out indefinitely.
- Reset mid-KEYEXP, ROUND or DONE: immediate return to the reset values; any partial schedule is invalidated (key_loaded=0).
- in_ready, key_ready are decoded from registered state plus key_valid only; no path from out_ready to in_ready.

## Structure
- Package aes192_pkg: FSM state enum, NR=12, NK=6, NWORDS=54, RCON table of 8 entries {01,02,04,08,10,20,40,80}.
- Sub-module aes192_inv_round (combinational): inputs state, round key, last_round flag; output next state. Built from inv_shift_rows, inv_subByte, add_round_key, inv_mix_columns (bypassed when last_round).
- Top holds the FSM, rnd/step counters, key store, state_reg and one key_expansion_192 instance.

## Test plan
- FIPS-197 C.2: key 000102…1617, data_in dda97ca4864cdfe06eaf70a0ec0d7191 → data_out 00112233445566778899aabbccddeeff, out_valid at T+13, key_loaded high at K+9.
- Two back-to-back blocks under one key with out_ready=1 → second in_ready at T+14, both plaintexts correct.
- out_ready held low 20 cycles in DONE → out_valid and data_out stable, in_ready=0, key_ready=0 throughout.
- key_valid and in_valid together in READY → key accepted, block not accepted, KEYEXP runs 8 cycles, then block under new key decrypts correctly.
- rst_n asserted in round 6 of ROUND → all outputs at reset values asynchronously; block after reload of the C.2 key gives correct plaintext.
- in_valid asserted in IDLE (no key) → in_ready stays 0, no out_valid.
